controle_contador: RTL
======================

# controle_contador

Sequencing controller for the 5-bit counter datapath: owns the count register and decides when it advances, in which direction, where it stops and when it reloads. Accepts start/stop/load commands from surrounding logic, runs the count at a programmable rate set by a prescaler, and flags the terminal count. It replaces the free-running counter wherever a bounded, restartable or periodic count is needed.

## Interface
- WIDTH, 5: count register width in bits.
- DIV, 1: prescaler. The count advances once every DIV clock cycles while running. Legal range is DIV ≥ 1.

Ports:
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge.
- start  input  1  command: begin or resume counting.
- stop  input  1  command: pause counting, or return to idle from DONE.
- load  input  1  command: Q <= din and base <= din.
- din  input  WIDTH  load value.
- limit  input  WIDTH  terminal count value.
- up  input  1  direction: 1 counts up, 0 counts down.
- auto_reload  input  1  at terminal: 1 reloads base and keeps running, 0 stops in DONE.
- Q  output  WIDTH  current count (registered).
- busy  output  1  high exactly when state is RUN.
- done  output  1  one-cycle pulse on each terminal event.
- state  output  2  state encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Reset (reset=0 at an edge):
  - Q=0, base=0, prescaler=0.
  - state=IDLE, busy=0, done=0.
  - Overrides every other input.
- Command priority at each edge: reset > load > stop > start > advance.
- load (any state):
  - Q<=din, base<=din, prescaler<=0.
  - State unchanged; no advance that cycle.
- IDLE:
  - start → RUN with base<=Q and prescaler<=0.
  - stop is ignored.
  - start and stop together → stay IDLE.
- RUN:
  - stop → PAUSE; Q and base held.
  - Otherwise the prescaler increments each cycle. On the cycle it equals DIV-1 it returns to 0 and an advance occurs.
- Advance, non-terminal (Q≠limit): Q <= Q+1 if up=1, else Q−1, both modulo 2^WIDTH (31+1→0, 0−1→31).
- Advance, terminal (Q==limit):
  - done=1 for one cycle.
  - auto_reload=1: Q<=base and state stays RUN.
  - auto_reload=0: state → DONE and Q holds limit.
- PAUSE:
  - start → RUN (resume). Q, base and prescaler are kept.
  - stop is ignored.
- DONE:
  - start → RUN with Q<=base and prescaler<=0 (restart).
  - stop → IDLE with Q held.
- up, limit and auto_reload are sampled at every advance. Changing them mid-run takes effect at the next advance.
- If Q already equals limit when RUN is entered, the first advance is terminal.
- done is 0 in every cycle that is not a terminal event.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Command latency: a command sampled at edge k is visible on Q/state/busy after edge k.
- First advance: at edge k+DIV after start at edge k.
- Subsequent advances: every DIV edges.
- done rises after the terminal advance edge and clears at the next edge.
- Reset mid-operation: outputs reach their reset values after the sampling edge, regardless of state or pending commands.

## Test plan
- Bounded up-count (DIV=1):
  - Stimulus: reset=0 for 2 cycles → Q=0, state=00, busy=0, done=0. Then up=1, limit=5, auto_reload=0, start pulse.
  - Response: Q=0,1,2,3,4,5 on successive edges. Next edge: done=1 for one cycle, state=11, busy=0, Q stays 5.
- Down-count wrap-around:
  - Stimulus: load din=2, up=0, limit=30, start.
  - Response: Q=1,0,31,30. Next edge: done pulse, state=DONE, Q=30.
- Auto-reload:
  - Stimulus: load din=3, limit=6, up=1, auto_reload=1, start.
  - Response: Q=4,5,6,3,4,5,6,3… busy stays 1. done pulses in the cycle Q returns to 3.
- Pause/resume and DONE restart:
  - Stimulus: stop while Q=4 (limit=10).
  - Response: state=10, Q=4 for 5 cycles. start resumes with Q=5 on the next edge.
  - After DONE, start gives Q=base and state=01.
- Reset and priority:
  - Stimulus: reset=0 while RUN at Q=10.
  - Response: Q=0, state=00 on the next edge.
  - In IDLE, start+stop together → stays IDLE.
  - load+stop together in RUN → Q=din and state=PAUSE.
- Prescaler (DIV=3 instance):
  - Stimulus: start from Q=0.
  - Response: Q advances at edges 3, 6, 9 after start.
  - A load at edge 4 restarts the prescaler, so the next advance is at edge 7.

Source files
------------

// File: rtl/controle_contador.sv
// controle_contador: start/stop/load sequencer owning a prescaled, bounded up/down count register
module controle_contador #(
  parameter int WIDTH = 5,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t state_q;
  logic [WIDTH-1:0] q_q, base_q, step_d;
  logic [PW-1:0] presc_q, presc_d;
  logic busy_q, done_q, tick_d;
  // prescaler wrap detection and the next count value in the selected direction
  always_comb begin
    tick_d  = presc_q == LAST;
    presc_d = tick_d ? '0 : presc_q + PW'(1);
    step_d  = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
  end
  // command sequencing: load owns the datapath that cycle but a simultaneous stop still moves the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      base_q  <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        q_q     <= din;
        base_q  <= din;
        presc_q <= '0;
        if (stop && state_q == RUN) begin
          state_q <= PAUSE;
          busy_q  <= 1'b0;
        end else if (stop && state_q == DONE) begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            base_q  <= q_q;
            presc_q <= '0;
          end
          RUN: if (stop) begin
            state_q <= PAUSE;
            busy_q  <= 1'b0;
          end else begin
            presc_q <= presc_d;
            if (tick_d && q_q == limit) begin
              done_q <= 1'b1;
              if (auto_reload) q_q <= base_q;
              else begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end
            end else if (tick_d) q_q <= step_d;
          end
          PAUSE: if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
          DONE: if (stop) state_q <= IDLE;
          else if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            q_q     <= base_q;
            presc_q <= '0;
          end
        endcase
      end
    end
  end
  assign Q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;
endmodule
